// File: rtl/alg_amba_vip_apb_pkg.sv
// rtl/alg_amba_vip_apb_pkg.sv - shared types and helpers for the APB memory responder
package alg_amba_vip_apb_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;
  typedef enum logic {OKAY, SLVERR} apb_resp_e;

  localparam int unsigned APB_WORD_BYTES = 4;

  // Widened to 64 bits so base + size cannot wrap at the top of the address map.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input int unsigned depth);
    return (addr >= base) && (addr < base + 64'(depth) * 64'(APB_WORD_BYTES));
  endfunction

endpackage

// File: rtl/alg_amba_vip_apb_regarray.sv
// rtl/alg_amba_vip_apb_regarray.sv - DEPTH x DATA_W register array, one write port, async read
module alg_amba_vip_apb_regarray #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alg_amba_vip_apb_mem_responder.sv
// rtl/alg_amba_vip_apb_mem_responder.sv - APB completer with programmable waits, SLVERR and protocol checks
module alg_amba_vip_apb_mem_responder
  import alg_amba_vip_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              slverr,
  input  logic [3:0]        wait_cfg,
  input  logic              err_inject,
  output logic              proto_err,
  output logic [15:0]       xfer_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_state_e        state_q, state_d;
  apb_resp_e         resp_q, resp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rhold_q, rhold_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              slverr_q, slverr_d;
  logic              proto_q, proto_d;
  logic [15:0]       xfer_q, xfer_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] off_in, off_q;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;
  logic              setup_err;
  logic [DATA_W-1:0] setup_rdata;

  assign off_in = addr - BASE_ADDR;
  assign off_q  = addr_q - BASE_ADDR;
  assign rd_idx = off_in[IDX_W+1:2];
  assign wr_idx = off_q[IDX_W+1:2];

  logic unused_off;
  assign unused_off = ^{off_in[1:0], off_in[ADDR_W-1:IDX_W+2], off_q[1:0], off_q[ADDR_W-1:IDX_W+2]};

  assign setup_err = !addr_in_range(64'(addr), 64'(BASE_ADDR), int'(DEPTH))
                   | (addr[1:0] != 2'b00) | err_inject;
  // Read data is captured at SETUP so the response reflects the array as it stood then.
  assign setup_rdata = (!write && !setup_err) ? arr_rdata : '0;

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rhold_d  = rhold_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rdata_d  = '0;
    slverr_d = 1'b0;
    proto_d  = proto_q;
    xfer_d   = xfer_q;
    done_d   = 1'b0;
    arr_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !done_q) proto_d = 1'b1;
        if (sel && !enable) begin
          state_d = ACCESS;
          addr_d  = addr;
          write_d = write;
          wdata_d = wdata;
          resp_d  = setup_err ? SLVERR : OKAY;
          rhold_d = setup_rdata;
          cnt_d   = wait_cfg;
          if (wait_cfg == 4'd0) begin
            ready_d  = 1'b1;
            rdata_d  = setup_rdata;
            slverr_d = setup_err;
          end
        end
      end
      ACCESS: begin
        if (!sel) begin
          proto_d = 1'b1;
          state_d = IDLE;
        end else begin
          if (addr != addr_q || write != write_q || wdata != wdata_q) proto_d = 1'b1;
          if (enable && ready_q) begin
            arr_we  = write_q && (resp_q == OKAY);
            xfer_d  = xfer_q + 16'd1;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (ready_q) begin
            ready_d  = 1'b1;
            rdata_d  = rdata_q;
            slverr_d = slverr_q;
          end else begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            // A count of one now means the next access cycle is the completing one.
            if (cnt_q <= 4'd1) begin
              ready_d  = 1'b1;
              rdata_d  = rhold_q;
              slverr_d = (resp_q == SLVERR);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      resp_q   <= OKAY;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rhold_q  <= '0;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      proto_q  <= 1'b0;
      xfer_q   <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rhold_q  <= rhold_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      proto_q  <= proto_d;
      xfer_q   <= xfer_d;
      done_q   <= done_d;
    end
  end

  alg_amba_vip_apb_regarray #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_regarray (
    .clk  (clk),
    .rstn (rstn),
    .we   (arr_we),
    .waddr(wr_idx),
    .wdata(wdata_q),
    .raddr(rd_idx),
    .rdata(arr_rdata)
  );

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign slverr    = slverr_q;
  assign proto_err = proto_q;
  assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_alg_amba_vip_apb_mem_responder.sv
// tb/tb_alg_amba_vip_apb_mem_responder.sv - randomized self-checking bench for the APB memory responder
module tb_alg_amba_vip_apb_mem_responder;

  localparam int          DEPTH = 64;
  localparam longint      BASE  = 0;
  localparam longint      LIMIT = BASE + DEPTH * 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel, enable, write, err_inject;
  logic [31:0] addr, wdata;
  logic [3:0]  wait_cfg;
  logic        ready, slverr, proto_err;
  logic [31:0] rdata;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  alg_amba_vip_apb_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .enable(enable), .addr(addr), .write(write),
    .wdata(wdata), .ready(ready), .rdata(rdata), .slverr(slverr), .wait_cfg(wait_cfg),
    .err_inject(err_inject), .proto_err(proto_err), .xfer_cnt(xfer_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_m [DEPTH];
  int unsigned xfer_m;
  logic        proto_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic err_m(input logic [31:0] a, input logic inj);
    longint la;
    la = longint'(a);
    return (la < BASE) || (la >= LIMIT) || (a[1:0] != 2'b00) || inj;
  endfunction

  function automatic int idx_m(input logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    xfer_m  = 0;
    proto_m = 1'b0;
  endtask

  // Called with inputs idle; returns at the negedge after completion with sel/enable low.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w, input logic inj, input logic idle_after);
    logic        e;
    logic [31:0] exp_r;
    int          k;
    logic        got;
    e     = err_m(a, inj);
    exp_r = (!wr && !e) ? mem_m[idx_m(a)] : 32'h0;
    sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d; wait_cfg = w; err_inject = inj;
    @(posedge clk); #1;
    enable     = 1'b1;
    wait_cfg   = 4'($urandom);
    err_inject = 1'($urandom);
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (ready === 1'b1) got = 1'b1;
      else @(posedge clk);
    end
    check("latency", k, 32'(w) + 32'd1);
    check("rdata", rdata, exp_r);
    check("slverr", {31'b0, slverr}, {31'b0, e});
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    if (wr && !e) mem_m[idx_m(a)] = d;
    xfer_m = (xfer_m + 1) % 65536;
    @(negedge clk);
    check("ready_drop", {31'b0, ready}, 32'h0);
    check("rdata_idle", rdata, 32'h0);
    check("xfer_cnt", {16'b0, xfer_cnt}, xfer_m);
    check("proto_err", {31'b0, proto_err}, {31'b0, proto_m});
    if (idle_after) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'(BASE) + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r == 7) return 32'(BASE) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'(LIMIT) + 32'(4 * $urandom_range(0, 15));
    else             return $urandom;
  endfunction

  initial begin
    rstn = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    wait_cfg = '0; err_inject = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_slverr", {31'b0, slverr}, 32'h0);
    check("rst_proto", {31'b0, proto_err}, 32'h0);
    check("rst_xfer", {16'b0, xfer_cnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'd0, 1'b0, 1'b1);
    xfer(1'b0, 32'h4, 32'h0, 4'd0, 1'b0, 1'b1);
    check("two_xfers", {16'b0, xfer_cnt}, 32'd2);

    xfer(1'b0, 32'h0, 32'h0, 4'd5, 1'b0, 1'b1);
    xfer(1'b1, 32'h100, 32'hA5A5A5A5, 4'd0, 1'b0, 1'b1);
    xfer(1'b1, 32'h2, 32'h11111111, 4'd1, 1'b0, 1'b1);
    xfer(1'b1, 32'h8, 32'h1234, 4'd2, 1'b1, 1'b1);
    xfer(1'b0, 32'h8, 32'h0, 4'd0, 1'b0, 1'b1);
    xfer(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h20 + 32'(4 * i), $urandom, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) xfer(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'd1, 1'b0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      xfer(1'($urandom), rand_addr(), $urandom,
           ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 4)),
           ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    check("no_false_proto", {31'b0, proto_err}, 32'h0);

    sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'hC; wdata = 32'hFFFF_FFFF;
    wait_cfg = 4'd3; err_inject = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, ready}, 32'h0);
    @(negedge clk);
    proto_m = 1'b1;
    check("abort_proto", {31'b0, proto_err}, 32'h1);
    check("abort_xfer", {16'b0, xfer_cnt}, xfer_m);
    xfer(1'b0, 32'hC, 32'h0, 4'd0, 1'b0, 1'b1);
    check("proto_sticky", {31'b0, proto_err}, 32'h1);

    sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h10; wdata = 32'h5555_AAAA;
    wait_cfg = 4'd3; err_inject = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    model_reset();
    check("rstmid_ready", {31'b0, ready}, 32'h0);
    check("rstmid_xfer", {16'b0, xfer_cnt}, 32'h0);
    check("rstmid_proto", {31'b0, proto_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h10, 32'h0, 4'd0, 1'b0, 1'b1);
    xfer(1'b0, 32'h4, 32'h0, 4'd1, 1'b0, 1'b1);

    force dut.xfer_d = 16'hFFFE;
    @(posedge clk); #1;
    release dut.xfer_d;
    xfer_m = 32'hFFFE;
    @(negedge clk);
    check("preload_xfer", {16'b0, xfer_cnt}, xfer_m);
    for (int i = 0; i < 3; i++) xfer(1'b1, 32'h30, 32'(i), 4'd0, 1'b0, 1'b0);
    check("wrap_xfer", {16'b0, xfer_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alg_amba_vip_apb_mem_responder.md
Name: alg_amba_vip_apb_mem_responder

Overview:
- APB completer (responder) model for the allegro testbench.
- Terminates the master-side APB of a bridge/CDC stage and services each transfer from a local word-addressed register array.
- Wait states are programmable per transfer; SLVERR is generated for decode, alignment and injected errors.
- Monitors protocol legality of the initiator and reports violations on a sticky flag.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width (must be 32).
- DEPTH, 64, number of 32-bit words in the array (power of 2, >=2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4 aligned).

Ports:
- clk  in  1  single clock.
- rstn  in  1  synchronous, active-low reset.
- sel  in  1  APB PSEL.
- enable  in  1  APB PENABLE.
- addr  in  ADDR_W  APB PADDR, byte address.
- write  in  1  APB PWRITE.
- wdata  in  DATA_W  APB PWDATA.
- ready  out  1  APB PREADY.
- rdata  out  DATA_W  APB PRDATA.
- slverr  out  1  APB PSLVERR.
- wait_cfg  in  4  access-phase wait states for the next transfer; sampled in the SETUP cycle.
- err_inject  in  1  force SLVERR on the next transfer; sampled in the SETUP cycle.
- proto_err  out  1  sticky protocol-violation flag.
- xfer_cnt  out  16  count of completed transfers (OKAY and ERROR).

Behaviour:
- Reset (rstn=0 at a clk edge):
  - ready=0, rdata=0, slverr=0, proto_err=0, xfer_cnt=0.
  - FSM=IDLE; all array words=0.
  - Reset mid-transfer aborts the transfer with no array write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On sel=1 & enable=0 (SETUP), latch addr, write, wdata, wait_cfg and err_inject; go to ACCESS.
  - Compute err_q = (addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4)) | (addr[1:0]!=0) | err_inject.
  - Load the wait counter with wait_cfg.
  - If wait_cfg=0, set ready=1 so ready is high in the first access cycle.
- ACCESS:
  - ready is registered. It is high in access cycle wait_cfg+1 (counting the first cycle with enable=1 as cycle 1), and only in that cycle.
  - Latency from SETUP to the completing cycle is wait_cfg+1 clocks.
  - The counter decrements once per access cycle while ready=0 and saturates at 0.
- Completion (sel & enable & ready at a clk edge):
  - Write with err_q=0: array[(addr-BASE_ADDR)>>2] <= wdata.
  - xfer_cnt += 1, wrapping 16'hFFFF -> 0.
  - Next cycle: ready=0, slverr=0, rdata=0; FSM=IDLE.
- Response values in the ready cycle:
  - slverr=err_q.
  - Read with err_q=0: rdata=array word, as it stands at the SETUP edge.
  - Read with err_q=1: rdata=0.
  - Write: rdata=0.
  - Outside the ready cycle, rdata=0 and slverr=0.
- Errored writes never modify the array. A read of a word in the same cycle it is written cannot occur, because transfers are serialised.
- Back-to-back transfers: a new SETUP in the cycle immediately after completion is accepted (IDLE sees sel & !enable). No idle cycle is required.
- Protocol checks, each setting proto_err=1 until reset:
  - enable=1 in IDLE with no completion in the previous cycle.
  - sel=0 while in ACCESS before completion. Action: abort, return to IDLE, ready=0, no write, no xfer_cnt increment.
  - addr, write or wdata changing during ACCESS. Action: flag only; the latched values are still used.
- wait_cfg and err_inject changing during ACCESS have no effect on the current transfer.

Decomposition:
- Shared package alg_amba_vip_apb_pkg holds:
  - apb_state_e {IDLE, ACCESS}
  - apb_resp_e {OKAY, SLVERR}
  - localparam APB_WORD_BYTES=4
  - function addr_in_range(addr, base, depth)
- One sub-module, alg_amba_vip_apb_regarray:
  - DEPTH x 32 register array.
  - Synchronous reset clear.
  - Single write port, combinational read port.
- The FSM, counters and checks stay in the top module.

Test Plan:
- Write then read, zero wait: wait_cfg=0, write 0x0000_0004 <= 0xDEADBEEF, then read 0x4 -> ready is high in the first access cycle of each transfer; read rdata=0xDEADBEEF, slverr=0; xfer_cnt=2.
- Wait states: wait_cfg=5, read 0x0 after reset -> ready rises exactly 6 cycles after SETUP; rdata=0; wait_cfg changed to 0 mid-ACCESS does not shorten the transfer.
- Errors:
  - Write 0x0000_0100 (DEPTH=64, out of range) -> slverr=1, no array change.
  - Write 0x2 (misaligned) -> slverr=1.
  - err_inject=1 on a write of 0x8 <= 0x1234 -> slverr=1; a subsequent read of 0x8 returns 0.
- Back-to-back: 4 consecutive writes with no idle cycle, wait_cfg=1 -> all complete, each 2 cycles after its SETUP; xfer_cnt=4; readback is correct.
- Protocol abort: deassert sel in the second ACCESS cycle with wait_cfg=3 on a write of 0xC <= 0xFFFF_FFFF -> proto_err=1 (sticky), no write (readback 0), xfer_cnt unchanged, the next legal transfer completes normally.
- Reset mid-ACCESS plus counter wrap:
  - rstn=0 during ACCESS of a write -> ready=0 on the next cycle, the array is cleared, xfer_cnt=0.
  - After 65536 transfers -> xfer_cnt wraps to 0.
